// File: rtl/madnes_ebi_pkg.sv
// Shared types for the EBI write path: target regions, queued write entry
// and scheduler FSM states.
package madnes_ebi_pkg;

  localparam int unsigned EBI_ADDR_W = 14;
  localparam int unsigned EBI_DATA_W = 16;
  localparam int unsigned REGION_MSB = 15;

  typedef enum logic [1:0] {
    REG_VRAM    = 2'd0,
    REG_OAM     = 2'd1,
    REG_PALETTE = 2'd2,
    REG_CTRL    = 2'd3
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [EBI_ADDR_W-1:0] addr;
    logic [EBI_DATA_W-1:0] data;
    region_t               region;
  } ebi_wr_t;

  // VRAM and OAM are read by the renderer mid-frame, so they wait for vblank.
  function automatic logic region_gated(region_t r);
    return (r == REG_VRAM) || (r == REG_OAM);
  endfunction

  function automatic logic [3:0] region_strobe(region_t r);
    logic [3:0] s;
    case (r)
      REG_VRAM:    s = 4'b0001;
      REG_OAM:     s = 4'b0010;
      REG_PALETTE: s = 4'b0100;
      default:     s = 4'b1000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ebi_wr_fifo.sv
// In-order FIFO of EBI write entries; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module ebi_wr_fifo
  import madnes_ebi_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  ebi_wr_t                      push_data,
  input  logic                         pop,
  output ebi_wr_t                      head,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  ebi_wr_t          mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset; the pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[IDX_W-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

endmodule

// File: rtl/ebi_write_scheduler.sv
// Queues decoded MCU writes and issues them in order to one memory port,
// holding VRAM/OAM writes until vblank. Optional stats: WRITE_SCHED_STATS_EN.
module ebi_write_scheduler
  import madnes_ebi_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       ebi_address,
  input  logic [DATA_W-1:0] ebi_data,
  input  logic              ebi_data_ready,
  input  logic              vblank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        wr_sel,
  output logic              fifo_full,
  output logic              busy,
  output logic              overflow
`ifdef WRITE_SCHED_STATS_EN
  ,
  output logic [31:0]       issued_count,
  output logic [15:0]       dropped_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  sched_state_t      state, state_d;
  ebi_wr_t           push_entry, head;
  logic [PTR_W-1:0]  count;
  logic              full, empty;
  logic              push, pop, drop, head_ok;
  logic [3:0]        sel_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    push_entry.addr   = EBI_ADDR_W'(ebi_address[ADDR_W-1:0]);
    push_entry.data   = EBI_DATA_W'(ebi_data);
    push_entry.region = region_t'(ebi_address[REGION_MSB -: 2]);
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = ebi_data_ready && (!full || pop);
  assign drop = ebi_data_ready && !push;

  ebi_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    sel_d   = 4'b0000;
    addr_d  = wr_addr;
    data_d  = wr_data;
    head_ok = !region_gated(head.region) || vblank;
    case (state)
      ST_IDLE: begin
        if (!empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (empty) begin
          state_d = ST_IDLE;
        end else if (head_ok) begin
          pop    = 1'b1;
          sel_d  = region_strobe(head.region);
          addr_d = ADDR_W'(head.addr);
          data_d = DATA_W'(head.data);
          if ((count == PTR_W'(1)) && !ebi_data_ready) state_d = ST_IDLE;
        end else begin
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (vblank) state_d = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wr_sel   <= 4'b0000;
      wr_addr  <= '0;
      wr_data  <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_d;
      wr_sel  <= sel_d;
      wr_addr <= addr_d;
      wr_data <= data_d;
      if (drop) overflow <= 1'b1;
    end
  end

  assign fifo_full = full;
  assign busy      = !empty || (wr_sel != 4'b0000);

`ifdef WRITE_SCHED_STATS_EN
  // Issue count wraps; drop count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_count  <= '0;
      dropped_count <= '0;
    end else begin
      if (pop) issued_count <= issued_count + 32'd1;
      if (drop && (dropped_count != 16'hFFFF)) dropped_count <= dropped_count + 16'd1;
    end
  end
`endif

endmodule
